game_sequencer: RTL

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_sequencer_if.sv | 29 ++
 rtl/game_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer_if.sv
`default_nettype none
//==============================================================================
// game_sequencer_if : player/collision inputs and game-state outputs of the
//                     frame-tick game sequencer. Revision 1.0
//==============================================================================
interface game_sequencer_if;
  logic        flap;
  logic        hitColumn;
  logic [10:0] Ax;
  logic [10:0] Ay;
  logic [10:0] Bx;
  logic [10:0] By;
  logic [10:0] y_out;
  logic [9:0]  score;
  logic [1:0]  state;
  logic        game_over;
  logic        col_clear;

  modport master (
    input  flap, hitColumn,
    output Ax, Ay, Bx, By, y_out, score, state, game_over, col_clear
  );

  modport slave (
    output flap, hitColumn,
    input  Ax, Ay, Bx, By, y_out, score, state, game_over, col_clear
  );
endinterface
`default_nettype wire

// File: rtl/game_sequencer.sv
`default_nettype none
//==============================================================================
// game_sequencer : bird physics, scrolling pipe pair, scoring and game FSM,
//                  advanced once per frame tick. Revision 1.0
//==============================================================================
module game_sequencer #(
  parameter int SCREEN_W     = 640,
  parameter int PIPE_W       = 20,
  parameter int PIPE_SPACING = 340,
  parameter int SCROLL_STEP  = 2,
  parameter int BIRD_X       = 200,
  parameter int Y_INIT       = 240,
  parameter int FLOOR_Y      = 10,
  parameter int CEIL_Y       = 470,
  parameter int FLAP_VEL     = 8,
  parameter int GRAVITY      = 1,
  parameter int MAX_FALL     = 10,
  parameter int GAP_MIN      = 112
) (
  input  logic             gameClk,
  input  logic             reset,
  game_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    READY   = 2'd0,
    PLAYING = 2'd1,
    DYING   = 2'd2,
    OVER    = 2'd3
  } state_t;

  localparam logic [10:0]        C_AX_INIT  = 11'(SCREEN_W + PIPE_W);
  localparam logic [10:0]        C_BX_INIT  = 11'(SCREEN_W + PIPE_W + PIPE_SPACING);
  localparam logic [10:0]        C_Y_INIT   = 11'(Y_INIT);
  localparam logic [10:0]        C_FLOOR    = 11'(FLOOR_Y);
  localparam logic [10:0]        C_CEIL     = 11'(CEIL_Y);
  localparam logic [10:0]        C_WRAP_LIM = 11'(PIPE_W + SCROLL_STEP);
  localparam logic [10:0]        C_STEP     = 11'(SCROLL_STEP);
  localparam logic [10:0]        C_WRAP_ADD = 11'(2 * PIPE_SPACING - SCROLL_STEP);
  localparam logic [10:0]        C_BIRD_X   = 11'(BIRD_X);
  localparam logic [10:0]        C_GAP_MIN  = 11'(GAP_MIN);
  localparam logic signed [11:0] C_FLOOR_S  = 12'(FLOOR_Y);
  localparam logic signed [11:0] C_CEIL_S   = 12'(CEIL_Y);
  localparam logic signed [7:0]  C_FLAP_VEL = 8'(FLAP_VEL);
  localparam logic signed [7:0]  C_GRAVITY  = 8'(GRAVITY);
  localparam logic signed [7:0]  C_VEL_MIN  = 8'(-MAX_FALL);
  localparam logic [15:0]        C_SEED     = 16'hACE1;
  localparam logic [10:0]        C_SCORE_MAX = 11'd1023;

  state_t            r_state, w_state_nxt;
  logic [10:0]       r_ax, r_ay, r_bx, r_by, r_y;
  logic [10:0]       w_ax_nxt, w_ay_nxt, w_bx_nxt, w_by_nxt, w_y_nxt;
  logic signed [7:0] r_vel, w_vel_nxt;
  logic [9:0]        r_score, w_score_nxt;
  logic              r_col_clear, w_col_clear_nxt;
  logic              r_flap_d;
  logic [15:0]       r_lfsr;

  logic              w_flap_ev;
  logic              w_lfsr_fb;
  logic signed [11:0] w_y_sum;
  logic              w_ceil_hit, w_floor_hit;
  logic [10:0]       w_y_phys;
  logic signed [7:0] w_vel_dec, w_vel_grav;
  logic              w_a_wrap, w_b_wrap, w_a_pass, w_b_pass;
  logic [10:0]       w_ax_step, w_bx_step, w_gap_y;
  logic [10:0]       w_score_sum;

  assign w_flap_ev = bus.flap & ~r_flap_d;
  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  // Signed 12-bit sum so a fall below zero can never wrap to a huge height.
  assign w_y_sum     = $signed({1'b0, r_y}) + $signed({{4{r_vel[7]}}, r_vel});
  assign w_ceil_hit  = (w_y_sum > C_CEIL_S);
  assign w_floor_hit = (w_y_sum <= C_FLOOR_S);
  assign w_y_phys    = w_ceil_hit  ? C_CEIL  :
                       w_floor_hit ? C_FLOOR : w_y_sum[10:0];
  assign w_vel_dec   = r_vel - C_GRAVITY;
  assign w_vel_grav  = (w_vel_dec < C_VEL_MIN) ? C_VEL_MIN : w_vel_dec;

  assign w_a_wrap  = (r_ax < C_WRAP_LIM);
  assign w_b_wrap  = (r_bx < C_WRAP_LIM);
  assign w_ax_step = w_a_wrap ? (r_ax + C_WRAP_ADD) : (r_ax - C_STEP);
  assign w_bx_step = w_b_wrap ? (r_bx + C_WRAP_ADD) : (r_bx - C_STEP);
  assign w_gap_y   = C_GAP_MIN + {3'b000, r_lfsr[7:0]};
  assign w_a_pass  = (r_ax > C_BIRD_X) && (w_ax_step <= C_BIRD_X);
  assign w_b_pass  = (r_bx > C_BIRD_X) && (w_bx_step <= C_BIRD_X);
  assign w_score_sum = {1'b0, r_score} + {10'd0, w_a_pass} + {10'd0, w_b_pass};

  always_comb begin
    w_state_nxt     = r_state;
    w_ax_nxt        = r_ax;
    w_ay_nxt        = r_ay;
    w_bx_nxt        = r_bx;
    w_by_nxt        = r_by;
    w_y_nxt         = r_y;
    w_vel_nxt       = r_vel;
    w_score_nxt     = r_score;
    w_col_clear_nxt = 1'b0;

    case (r_state)
      READY: begin
        // Score clear lands here, one tick after leaving OVER.
        w_score_nxt = '0;
        if (w_flap_ev) begin
          w_state_nxt = PLAYING;
          w_vel_nxt   = C_FLAP_VEL;
        end
      end
      PLAYING: begin
        w_y_nxt   = w_y_phys;
        w_vel_nxt = w_ceil_hit ? 8'sd0 : (w_flap_ev ? C_FLAP_VEL : w_vel_grav);
        if (bus.hitColumn || w_floor_hit) begin
          w_state_nxt = DYING;
        end else begin
          w_ax_nxt = w_ax_step;
          w_bx_nxt = w_bx_step;
          if (w_a_wrap) w_ay_nxt = w_gap_y;
          if (w_b_wrap) w_by_nxt = w_gap_y;
          w_score_nxt = (w_score_sum > C_SCORE_MAX) ? 10'd1023 : w_score_sum[9:0];
        end
      end
      DYING: begin
        w_y_nxt   = w_y_phys;
        w_vel_nxt = w_ceil_hit ? 8'sd0 : w_vel_grav;
        if (w_floor_hit) w_state_nxt = OVER;
      end
      OVER: begin
        if (w_flap_ev) begin
          w_state_nxt     = READY;
          w_ax_nxt        = C_AX_INIT;
          w_bx_nxt        = C_BX_INIT;
          w_ay_nxt        = C_Y_INIT;
          w_by_nxt        = C_Y_INIT;
          w_y_nxt         = C_Y_INIT;
          w_vel_nxt       = 8'sd0;
          w_col_clear_nxt = 1'b1;
        end
      end
      default: w_state_nxt = READY;
    endcase
  end

  always_ff @(posedge gameClk or negedge reset) begin
    if (!reset) begin
      r_state     <= READY;
      r_ax        <= C_AX_INIT;
      r_bx        <= C_BX_INIT;
      r_ay        <= C_Y_INIT;
      r_by        <= C_Y_INIT;
      r_y         <= C_Y_INIT;
      r_vel       <= 8'sd0;
      r_score     <= '0;
      r_col_clear <= 1'b0;
      r_flap_d    <= 1'b0;
      r_lfsr      <= C_SEED;
    end else begin
      r_state     <= w_state_nxt;
      r_ax        <= w_ax_nxt;
      r_bx        <= w_bx_nxt;
      r_ay        <= w_ay_nxt;
      r_by        <= w_by_nxt;
      r_y         <= w_y_nxt;
      r_vel       <= w_vel_nxt;
      r_score     <= w_score_nxt;
      r_col_clear <= w_col_clear_nxt;
      r_flap_d    <= bus.flap;
      r_lfsr      <= {r_lfsr[14:0], w_lfsr_fb};
    end
  end

  assign bus.Ax        = r_ax;
  assign bus.Ay        = r_ay;
  assign bus.Bx        = r_bx;
  assign bus.By        = r_by;
  assign bus.y_out     = r_y;
  assign bus.score     = r_score;
  assign bus.state     = r_state;
  assign bus.game_over = (r_state == OVER);
  assign bus.col_clear = r_col_clear;

endmodule
`default_nettype wire
